// File: rtl/barramento_snooping_if.sv
// Purpose : request/response and bus-observation signals of the snoop-bus controller.
// Latency : none (pure signal bundle).
// Backpress: requests are held by the processors until their ack pulse.
// Ports   : req/op/linha (processor requests), ack, ocupado, bus_owner, bus_msg,
//           mem_read, mem_write_back, aborta_acesso_mem, estado_tabela.
interface barramento_snooping_if;
  logic [2:0]  req;
  logic [2:0]  op;
  logic [5:0]  linha;
  logic [2:0]  ack;
  logic        ocupado;
  logic [1:0]  bus_owner;
  logic [1:0]  bus_msg;
  logic        mem_read;
  logic        mem_write_back;
  logic        aborta_acesso_mem;
  logic [23:0] estado_tabela;

  // Processor/memory side: drives requests, observes the controller.
  modport master (
    output req, op, linha,
    input  ack, ocupado, bus_owner, bus_msg, mem_read, mem_write_back,
           aborta_acesso_mem, estado_tabela
  );

  // Controller side.
  modport slave (
    input  req, op, linha,
    output ack, ocupado, bus_owner, bus_msg, mem_read, mem_write_back,
           aborta_acesso_mem, estado_tabela
  );
endinterface

// File: rtl/barramento_snooping.sv
// Purpose : 3-processor MSI snoop-bus controller: round-robin arbitration, per-line
//           state table, one bus message per transaction, memory read or owner write-back.
// Latency : hit 2 cycles, invalidate 3, memory miss 3+MEM_LAT, supplied miss 3+WB_LAT.
// Backpress: one transaction at a time; other requesters hold req until their ack.
// Ports   : i_clk, i_rst (async, active-high), bus (barramento_snooping_if.slave).
module barramento_snooping #(
  parameter int MEM_LAT = 2,
  parameter int WB_LAT  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  barramento_snooping_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_SNOOP = 3'd2,
    S_WB    = 3'd3,
    S_MEM   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;

  localparam logic [1:0] MSG_NONE = 2'b00;
  localparam logic [1:0] MSG_WM   = 2'b01;
  localparam logic [1:0] MSG_INV  = 2'b10;
  localparam logic [1:0] MSG_RM   = 2'b11;

  localparam logic [7:0] MEM_CNT_INIT = 8'(MEM_LAT - 1);
  localparam logic [7:0] WB_CNT_INIT  = 8'(WB_LAT - 1);

  state_t      r_state;
  state_t      w_next;

  logic [1:0]  r_owner;
  logic [1:0]  r_last;      // last granted processor; search starts after it
  logic        r_op;
  logic [1:0]  r_line;
  logic [1:0]  r_msg;
  logic [7:0]  r_cnt;
  logic [23:0] r_tab;

  logic        w_gnt_vld;
  logic [1:0]  w_gnt_idx;
  logic [1:0]  w_c0, w_c1, w_c2;

  logic [4:0]  w_own_base;
  logic [1:0]  w_own_s;
  logic [1:0]  w_own_new;
  logic        w_hit;
  logic [1:0]  w_check_msg;

  logic [23:0] w_tab_snoop;
  logic        w_supply;
  logic [4:0]  w_base;
  logic [1:0]  w_s;

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Round-robin grant: candidates in order after the last owner.
  always_comb begin
    w_c0      = rr_next(r_last);
    w_c1      = rr_next(w_c0);
    w_c2      = rr_next(w_c1);
    w_gnt_vld = 1'b1;
    w_gnt_idx = w_c0;
    if (bus.req[w_c0])      w_gnt_idx = w_c0;
    else if (bus.req[w_c1]) w_gnt_idx = w_c1;
    else if (bus.req[w_c2]) w_gnt_idx = w_c2;
    else                    w_gnt_vld = 1'b0;
  end

  // Owner's view of the latched line and the transaction classification.
  always_comb begin
    w_own_base  = {r_owner, 3'b000} + {2'b00, r_line, 1'b0};
    w_own_s     = r_tab[w_own_base +: 2];
    w_hit       = r_op ? (w_own_s == ST_E) : (w_own_s != ST_I);
    w_check_msg = MSG_NONE;
    if (r_op && (w_own_s == ST_S)) w_check_msg = MSG_INV;
    else if (r_op)                 w_check_msg = MSG_WM;
    else                           w_check_msg = MSG_RM;
    // A read hit keeps its state; a read miss lands shared; writes end exclusive.
    if (r_op)                   w_own_new = ST_E;
    else if (w_own_s != ST_I)   w_own_new = w_own_s;
    else                        w_own_new = ST_S;
  end

  // Receiver-side transitions applied to every non-owner copy of the line.
  always_comb begin
    w_tab_snoop = r_tab;
    w_supply    = 1'b0;
    w_base      = 5'd0;
    w_s         = ST_I;
    for (int p = 0; p < 3; p++) begin
      w_base = 5'(8 * p) + {2'b00, r_line, 1'b0};
      w_s    = r_tab[w_base +: 2];
      if (2'(p) != r_owner) begin
        case (w_s)
          ST_E: begin
            if (r_msg == MSG_RM) begin
              w_tab_snoop[w_base +: 2] = ST_S;
              w_supply                 = 1'b1;
            end else if (r_msg == MSG_WM) begin
              w_tab_snoop[w_base +: 2] = ST_I;
              w_supply                 = 1'b1;
            end
          end
          ST_S: begin
            if ((r_msg == MSG_WM) || (r_msg == MSG_INV))
              w_tab_snoop[w_base +: 2] = ST_I;
          end
          default: ;
        endcase
      end
    end
  end

  // FSM: state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM: next state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_vld) w_next = S_CHECK;
      S_CHECK: w_next = w_hit ? S_DONE : S_SNOOP;
      S_SNOOP: begin
        if (r_msg == MSG_INV) w_next = S_DONE;
        else if (w_supply)    w_next = S_WB;
        else                  w_next = S_MEM;
      end
      S_WB:    if (r_cnt == 8'd0) w_next = S_DONE;
      S_MEM:   if (r_cnt == 8'd0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs (Moore, decoded from state).
  always_comb begin
    bus.ack               = 3'b000;
    bus.ocupado           = (r_state != S_IDLE);
    bus.bus_owner         = r_owner;
    bus.bus_msg           = MSG_NONE;
    bus.mem_read          = 1'b0;
    bus.mem_write_back    = 1'b0;
    bus.aborta_acesso_mem = 1'b0;
    bus.estado_tabela     = r_tab;
    case (r_state)
      S_SNOOP: bus.bus_msg = r_msg;
      S_WB: begin
        bus.mem_write_back    = 1'b1;
        bus.aborta_acesso_mem = 1'b1;
      end
      S_MEM:   bus.mem_read = 1'b1;
      S_DONE:  bus.ack = 3'b001 << r_owner;
      default: ;
    endcase
  end

  // Datapath: latched request, latency counter and the coherence table.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_owner <= 2'd0;
      r_last  <= 2'd2;   // so processor 0 is the first candidate
      r_op    <= 1'b0;
      r_line  <= 2'd0;
      r_msg   <= MSG_NONE;
      r_cnt   <= 8'd0;
      r_tab   <= 24'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_owner <= w_gnt_idx;
            r_op    <= bus.op[w_gnt_idx];
            r_line  <= bus.linha[{w_gnt_idx, 1'b0} +: 2];
          end
        end
        S_CHECK: r_msg <= w_check_msg;
        S_SNOOP: begin
          r_tab <= w_tab_snoop;
          r_cnt <= w_supply ? WB_CNT_INIT : MEM_CNT_INIT;
        end
        S_WB, S_MEM: begin
          if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
        end
        S_DONE: begin
          r_tab[w_own_base +: 2] <= w_own_new;
          r_last                 <= r_owner;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_barramento_snooping.sv
// Purpose : directed self-checking bench for barramento_snooping (MEM_LAT=2, WB_LAT=1).
// Latency : cycle n of a transaction is observed 1 time unit after the n-th edge following req.
// Backpress: each requester holds req until its ack pulse, then drops it.
module tb_barramento_snooping;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  barramento_snooping_if bif();

  barramento_snooping #(.MEM_LAT(2), .WB_LAT(1)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bif)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Per-transaction observations.
  int          t_ack_cyc, t_msg_cyc, t_mr_n, t_mr_first, t_wb_n, t_ab_n;
  logic [2:0]  t_ack_val;
  logic [1:0]  t_msg;
  logic [23:0] t_est_ack;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    bif.req   = 3'b000;
    bif.op    = 3'b000;
    bif.linha = 6'd0;
    i_rst     = 1'b1;
    step();
    step();
    i_rst     = 1'b0;
    step();
  endtask

  // Issue one request from processor p and record what the controller does.
  task automatic run(input int p, input logic o, input logic [1:0] l);
    t_ack_cyc = -1; t_msg_cyc = -1; t_mr_n = 0; t_mr_first = -1;
    t_wb_n = 0; t_ab_n = 0; t_ack_val = 3'b000; t_msg = 2'b00; t_est_ack = 24'd0;
    bif.req[p]          = 1'b1;
    bif.op[p]           = o;
    bif.linha[2*p +: 2] = l;
    for (int c = 1; c <= 20 && t_ack_cyc < 0; c++) begin
      step();
      if (bif.bus_msg != 2'b00 && t_msg_cyc < 0) begin
        t_msg_cyc = c;
        t_msg     = bif.bus_msg;
      end
      if (bif.mem_read) begin
        t_mr_n++;
        if (t_mr_first < 0) t_mr_first = c;
      end
      if (bif.mem_write_back)    t_wb_n++;
      if (bif.aborta_acesso_mem) t_ab_n++;
      if (bif.ack != 3'b000) begin
        t_ack_cyc = c;
        t_ack_val = bif.ack;
        t_est_ack = bif.estado_tabela;
        bif.req[p] = 1'b0;
      end
    end
    step();  // owner update becomes visible here
  endtask

  task automatic expect_txn(input string tag, input int ack_c, input logic [2:0] ackv,
                            input logic [1:0] m, input int mc, input int mr, input int wb,
                            input logic [23:0] est);
    chk({tag, "_ack_cycle"}, t_ack_cyc, ack_c);
    chk({tag, "_ack_value"}, {29'd0, t_ack_val}, {29'd0, ackv});
    chk({tag, "_bus_msg"}, {30'd0, t_msg}, {30'd0, m});
    chk({tag, "_msg_cycle"}, t_msg_cyc, mc);
    chk({tag, "_mem_read_cycles"}, t_mr_n, mr);
    chk({tag, "_wb_cycles"}, t_wb_n, wb);
    chk({tag, "_abort_cycles"}, t_ab_n, wb);
    chk({tag, "_estado"}, {8'd0, bif.estado_tabela}, {8'd0, est});
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ack"}, {29'd0, bif.ack}, 32'd0);
    chk({tag, "_ocupado"}, {31'd0, bif.ocupado}, 32'd0);
    chk({tag, "_bus_owner"}, {30'd0, bif.bus_owner}, 32'd0);
    chk({tag, "_bus_msg"}, {30'd0, bif.bus_msg}, 32'd0);
    chk({tag, "_mem_read"}, {31'd0, bif.mem_read}, 32'd0);
    chk({tag, "_mem_wb"}, {31'd0, bif.mem_write_back}, 32'd0);
    chk({tag, "_aborta"}, {31'd0, bif.aborta_acesso_mem}, 32'd0);
    chk({tag, "_estado"}, {8'd0, bif.estado_tabela}, 32'd0);
  endtask

  initial begin
    int         acks_seen;
    logic [2:0] ack_seq [3];
    logic [1:0] own_seq [3];
    logic [2:0] any_ack;

    do_reset();
    check_idle_outputs("reset");

    // P0 read line 1: read_miss, memory path.
    run(0, 1'b0, 2'd1);
    expect_txn("p0_rd_l1", 5, 3'b001, 2'b11, 2, 2, 0, 24'h000004);
    chk("p0_rd_l1_mem_first", t_mr_first, 3);

    // P1 read line 1: P0 shared, no supplier, memory path.
    run(1, 1'b0, 2'd1);
    expect_txn("p1_rd_l1", 5, 3'b010, 2'b11, 2, 2, 0, 24'h000404);

    // P0 write line 1 (shared): invalidate; P1 invalid already at ack, P0 still shared.
    run(0, 1'b1, 2'd1);
    expect_txn("p0_wr_l1", 3, 3'b001, 2'b10, 2, 0, 0, 24'h000008);
    chk("p0_wr_l1_remote_first", {8'd0, t_est_ack}, 32'h000004);

    // P2 read line 1, P0 exclusive supplies: write-back path.
    run(2, 1'b0, 2'd1);
    expect_txn("p2_rd_l1", 4, 3'b100, 2'b11, 2, 0, 1, 24'h040004);

    // P0 write line 2 (invalid everywhere): write_miss, memory path.
    run(0, 1'b1, 2'd2);
    expect_txn("p0_wr_l2", 5, 3'b001, 2'b01, 2, 2, 0, 24'h040024);

    // P0 write hit on exclusive line 2: no bus traffic.
    run(0, 1'b1, 2'd2);
    expect_txn("p0_wr_hit", 2, 3'b001, 2'b00, -1, 0, 0, 24'h040024);

    // P1 write line 2, P0 exclusive supplies and is invalidated.
    run(1, 1'b1, 2'd2);
    expect_txn("p1_wr_l2", 4, 3'b010, 2'b01, 2, 0, 1, 24'h042004);

    // P2 read hit on shared line 1.
    run(2, 1'b0, 2'd1);
    expect_txn("p2_rd_hit", 2, 3'b100, 2'b00, -1, 0, 0, 24'h042004);

    // P1 write line 1: two shared copies invalidated, memory path.
    run(1, 1'b1, 2'd1);
    expect_txn("p1_wr_l1", 5, 3'b010, 2'b01, 2, 2, 0, 24'h002800);

    // Round robin: all three read distinct lines at once.
    do_reset();
    acks_seen = 0;
    bif.op    = 3'b000;
    bif.linha = 6'b10_01_00;
    bif.req   = 3'b111;
    for (int c = 0; c < 60 && acks_seen < 3; c++) begin
      step();
      if (bif.ack != 3'b000) begin
        ack_seq[acks_seen] = bif.ack;
        own_seq[acks_seen] = bif.bus_owner;
        acks_seen++;
        bif.req = bif.req & ~bif.ack;
      end
    end
    chk("rr_ack_count", acks_seen, 3);
    if (acks_seen == 3) begin
      chk("rr_ack0", {29'd0, ack_seq[0]}, 32'b001);
      chk("rr_ack1", {29'd0, ack_seq[1]}, 32'b010);
      chk("rr_ack2", {29'd0, ack_seq[2]}, 32'b100);
      chk("rr_own0", {30'd0, own_seq[0]}, 32'd0);
      chk("rr_own1", {30'd0, own_seq[1]}, 32'd1);
      chk("rr_own2", {30'd0, own_seq[2]}, 32'd2);
    end
    step();
    chk("rr_estado", {8'd0, bif.estado_tabela}, 32'h100401);

    // Reset during MEM aborts the transaction silently.
    bif.req[0]     = 1'b1;
    bif.op[0]      = 1'b0;
    bif.linha[1:0] = 2'd3;
    step(); step(); step();
    chk("mid_mem_read", {31'd0, bif.mem_read}, 32'd1);
    #2 i_rst = 1'b1;
    step();
    check_idle_outputs("rst_mid_mem");
    bif.req = 3'b000;
    i_rst   = 1'b0;
    any_ack = 3'b000;
    for (int c = 0; c < 6; c++) begin
      step();
      any_ack = any_ack | bif.ack;
    end
    chk("no_ack_after_abort", {29'd0, any_ack}, 32'd0);

    run(1, 1'b0, 2'd0);
    expect_txn("fresh_p1_rd_l0", 5, 3'b010, 2'b11, 2, 2, 0, 24'h000100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
